phv_parser: RTL and testbench
=============================

// Module: phv_parser
// PURPOSE
//  Packet parser feeding the first RMT stage. Captures the first 64 header bytes (2 beats) of each
//  AXI-Stream packet, fills the PHV containers from a configurable byte-offset parse table, and
//  emits one PHV per packet on phv_out/phv_out_valid, the exact input of stage 0. The packet is
//  forwarded unchanged on m_axis for the downstream packet buffer / deparser.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   256   tdata width; header window = 2 beats = 64 bytes
//  C_AXIS_TUSER_WIDTH  128   tuser width; copied into PHV metadata
//  PHV_LEN             48*8+32*8+16*8+5*20+256 (1124)   PHV width
//  PT_ENTRIES          24    parse-table entries, one per container (8x6B, 8x4B, 8x2B)
//  PT_ENTRY_W          7     {valid[6], byte_offset[5:0]}
// PORTS
//  axis_clk            in   1     clock
//  aresetn             in   1     asynchronous, active-low reset
//  s_axis_tdata        in   256   packet data; byte 0 = tdata[7:0] of beat 0
//  s_axis_tkeep        in   32    byte enables (pass-through only)
//  s_axis_tuser        in   128   per-packet metadata, sampled on beat 0
//  s_axis_tvalid       in   1     source valid
//  s_axis_tlast        in   1     last beat of packet
//  s_axis_tready       out  1     = m_axis_tready (combinational pass-through)
//  m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  forwarded packet, s_axis verbatim
//  m_axis_tready       in   1     downstream ready
//  phv_out             out  1124  parsed PHV
//  phv_out_valid       out  1     one-cycle pulse per packet; no backpressure
//  cfg_wr_en           in   1     parse-table write strobe
//  cfg_addr            in   5     container index 0..23 (0-7: 6B, 8-15: 4B, 16-23: 2B); >=24 ignored
//  cfg_data            in   7     {valid, byte_offset}
// BEHAVIOUR
//  Reset: phv_out=0, phv_out_valid=0, FSM=IDLE, header regs=0, all table entries=0 (invalid).
//  m_axis_* outputs are combinational copies of s_axis_*; beat accepted when tvalid&&tready.
//  FSM (advances only on accepted beats, except EMIT):
//   IDLE  : beat 0 accepted -> hdr[255:0]<=tdata, hdr[511:256]<=0, meta<=tuser;
//           tlast ? EMIT : BEAT1
//   BEAT1 : beat accepted -> hdr[511:256]<=tdata; tlast ? EMIT : DRAIN (next cycle EMIT once)
//   EMIT  : one cycle: build PHV, phv_out_valid=1 next cycle; -> DRAIN if packet not ended, else IDLE
//           (EMIT does not block s_axis; beats accepted in EMIT are tracked for tlast)
//   DRAIN : accept until tlast -> IDLE. Beats are never stalled by the parser.
//  Latency: phv_out_valid high exactly 2 cycles after the beat that completes the header
//   (beat 1, or beat 0 if tlast). phv_out holds its value until the next PHV.
//  Extraction (container i, width N bytes): if entry.valid, value = hdr bytes off..off+N-1,
//   byte off in MSBs (network order); bytes with index >=64 read as 0. Invalid entry -> 0.
//  PHV layout MSB->LSB: 6B c0..c7 | 4B c8..c15 | 2B c16..c23 | 100'b0 | {128'b0, meta}.
//   c0 occupies PHV[1123:1076].
//  Config: write lands on next edge; an EMIT in the same cycle as a write uses the old entry.
//  Back-to-back: new packet's beat 0 may arrive in cycle after tlast; DRAIN->IDLE handled so the
//   next packet's beat 0 accepted in IDLE; EMIT of previous packet never overwritten by it.
//  Reset mid-packet: everything returns to reset values; no PHV for the partial packet; the next
//   accepted beat is treated as beat 0.
// STRUCTURE
//  rmt_defines.vh: PHV_LEN, container counts/widths, PHV field offsets, PT_ENTRY_W, state encodings.
//  Sub-module phv_container_extract #(.BYTES(N)): combinational 64B header + entry -> N-byte value;
//   instantiated 24 times (generate). FSM, header regs, table, output reg in phv_parser.
// TESTING
//  1. tbl c0={1,0}, c8={1,26}, c16={1,12}; 2-beat pkt bytes[k]=k -> c0=0x000102030405,
//     c8=0x1A1B1C1D, c16=0x0C0D, other containers 0, valid pulse 2 cycles after beat 1.
//  2. 1-beat pkt (tlast on beat 0), c16={1,40}, tuser=0xABCD -> c16=0x0000, meta LSBs 0xABCD.
//  3. c0={1,60}, bytes[k]=k -> c0=0x3C3D3E3F0000 (overrun zero-fill).
//  4. 5-beat pkts back-to-back, m_axis_tready toggling 50% -> exactly one PHV per packet,
//     m_axis stream bit-identical to s_axis.
//  5. cfg write c8={1,4} in EMIT cycle -> that PHV uses old c8; next packet uses offset 4.
//  6. aresetn low during beat 1 of a packet -> no PHV; table cleared; next pkt parses with zeros.

Source files
------------

// File: rtl/phv_parser_pkg.sv
// Shared widths, PHV layout offsets, parse-table entry type and FSM states for the PHV parser.
package phv_parser_pkg;

  localparam int unsigned DATA_W     = 256;
  localparam int unsigned KEEP_W     = DATA_W / 8;
  localparam int unsigned USER_W     = 128;
  localparam int unsigned HDR_W      = 2 * DATA_W;
  localparam int unsigned PHV_LEN    = 1124;
  localparam int unsigned PT_ENTRIES = 24;
  localparam int unsigned PT_ENTRY_W = 7;
  localparam int unsigned OFF_W      = 6;
  localparam int unsigned CFG_ADDR_W = 5;

  localparam int unsigned N_C6 = 8;
  localparam int unsigned N_C4 = 8;
  localparam int unsigned N_C2 = 8;
  localparam int unsigned C6_W = 48;
  localparam int unsigned C4_W = 32;
  localparam int unsigned C2_W = 16;

  localparam int unsigned RSVD_W = 100;
  localparam int unsigned META_W = 256;
  // LSB position of each container group inside the PHV
  localparam int unsigned C2_LSB = META_W + RSVD_W;
  localparam int unsigned C4_LSB = C2_LSB + N_C2 * C2_W;
  localparam int unsigned C6_LSB = C4_LSB + N_C4 * C4_W;

  typedef struct packed {
    logic             valid;
    logic [OFF_W-1:0] offset;
  } pt_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/phv_parser_if.sv
// AXI-Stream bundle used for both the parser input and the forwarded packet output.
interface phv_parser_if;
  import phv_parser_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/phv_parser_extract.sv
// Pulls one N-byte container out of the 64-byte header window, first byte in the MSBs.
module phv_container_extract
  import phv_parser_pkg::*;
#(
  parameter int unsigned BYTES = 2
) (
  input  logic [HDR_W-1:0]   hdr,
  input  pt_entry_t          entry,
  output logic [8*BYTES-1:0] value
);

  logic [6:0] idx;

  // bytes past the end of the window read as zero
  always_comb begin
    value = '0;
    idx   = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      idx = 7'(entry.offset) + 7'(k);
      if (entry.valid && !idx[6]) begin
        value[8*(BYTES-1-k) +: 8] = hdr[{idx[5:0], 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/phv_parser.sv
// Header capture, parse table and PHV build for RMT stage 0; the packet passes through untouched.
module phv_parser
  import phv_parser_pkg::*;
(
  input  logic                  axis_clk,
  input  logic                  aresetn,
  phv_parser_if.slave           s_axis,
  phv_parser_if.master          m_axis,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid,
  input  logic                  cfg_wr_en,
  input  logic [CFG_ADDR_W-1:0] cfg_addr,
  input  logic [PT_ENTRY_W-1:0] cfg_data
);

  state_t              state, state_nx;
  logic                ended, ended_nx;
  logic                cap0, cap1, emit, accept;
  logic [DATA_W-1:0]   hdr_lo, hdr_hi;
  logic [USER_W-1:0]   meta;
  logic [HDR_W-1:0]    hdr;
  logic [PHV_LEN-1:0]  phv_c;
  pt_entry_t           tbl [PT_ENTRIES];
  logic [C6_W-1:0]     v6 [N_C6];
  logic [C4_W-1:0]     v4 [N_C4];
  logic [C2_W-1:0]     v2 [N_C2];

  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tuser  = s_axis.tuser;
  assign m_axis.tvalid = s_axis.tvalid;
  assign m_axis.tlast  = s_axis.tlast;
  assign s_axis.tready = m_axis.tready;

  assign accept = s_axis.tvalid & m_axis.tready;
  assign hdr    = {hdr_hi, hdr_lo};

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      ended <= 1'b0;
    end else begin
      state <= state_nx;
      ended <= ended_nx;
    end
  end

  // A beat arriving in EMIT after the packet already ended is the next packet's beat 0
  always_comb begin
    state_nx = state;
    ended_nx = ended;
    cap0     = 1'b0;
    cap1     = 1'b0;
    emit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cap0     = 1'b1;
          ended_nx = s_axis.tlast;
          state_nx = s_axis.tlast ? ST_EMIT : ST_BEAT1;
        end
      end
      ST_BEAT1: begin
        if (accept) begin
          cap1     = 1'b1;
          ended_nx = s_axis.tlast;
          state_nx = ST_EMIT;
        end
      end
      ST_EMIT: begin
        emit = 1'b1;
        if (ended) begin
          if (accept) begin
            cap0     = 1'b1;
            ended_nx = s_axis.tlast;
            state_nx = s_axis.tlast ? ST_EMIT : ST_BEAT1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (accept && s_axis.tlast) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept && s_axis.tlast) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Header window and per-packet metadata
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      hdr_lo <= '0;
      hdr_hi <= '0;
      meta   <= '0;
    end else if (cap0) begin
      hdr_lo <= s_axis.tdata;
      hdr_hi <= '0;
      meta   <= s_axis.tuser;
    end else if (cap1) begin
      hdr_hi <= s_axis.tdata;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(PT_ENTRIES); i++) tbl[i] <= '0;
    end else if (cfg_wr_en && (cfg_addr < CFG_ADDR_W'(PT_ENTRIES))) begin
      tbl[cfg_addr] <= pt_entry_t'(cfg_data);
    end
  end

  for (genvar i = 0; i < int'(N_C6); i++) begin : g_c6
    phv_container_extract #(.BYTES(C6_W / 8)) u_ext (.hdr(hdr), .entry(tbl[i]), .value(v6[i]));
  end
  for (genvar i = 0; i < int'(N_C4); i++) begin : g_c4
    phv_container_extract #(.BYTES(C4_W / 8)) u_ext (.hdr(hdr), .entry(tbl[N_C6 + i]), .value(v4[i]));
  end
  for (genvar i = 0; i < int'(N_C2); i++) begin : g_c2
    phv_container_extract #(.BYTES(C2_W / 8)) u_ext (.hdr(hdr), .entry(tbl[N_C6 + N_C4 + i]), .value(v2[i]));
  end

  // Container 0 of each group sits at the group's MSB end
  always_comb begin
    phv_c = '0;
    for (int unsigned i = 0; i < N_C6; i++) phv_c[C6_LSB + C6_W*(N_C6-1-i) +: C6_W] = v6[i];
    for (int unsigned i = 0; i < N_C4; i++) phv_c[C4_LSB + C4_W*(N_C4-1-i) +: C4_W] = v4[i];
    for (int unsigned i = 0; i < N_C2; i++) phv_c[C2_LSB + C2_W*(N_C2-1-i) +: C2_W] = v2[i];
    phv_c[USER_W-1:0] = meta;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
    end else begin
      phv_out_valid <= emit;
      if (emit) phv_out <= phv_c;
    end
  end

endmodule

// File: tb/tb_phv_parser.sv
// Scoreboard bench for phv_parser: directed packets push expected PHVs, a monitor pops and compares.
module tb_phv_parser;
  import phv_parser_pkg::*;

  logic                  axis_clk = 1'b0;
  logic                  aresetn;
  logic                  cfg_wr_en;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [PT_ENTRY_W-1:0] cfg_data;
  logic [PHV_LEN-1:0]    phv_out;
  logic                  phv_out_valid;

  phv_parser_if s_axis ();
  phv_parser_if m_axis ();

  phv_parser dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .phv_out       (phv_out),
    .phv_out_valid (phv_out_valid),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [PHV_LEN-1:0] phv;
    int                 exp_cyc;
  } exp_t;

  exp_t         sb[$];
  logic [47:0]  e6 [8];
  logic [31:0]  e4 [8];
  logic [15:0]  e2 [8];
  logic [127:0] emeta;
  int           npass = 0;
  int           nchk  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] bv(input int k, input int p);
    return 8'(k + 7 * p);
  endfunction

  function automatic logic [PHV_LEN-1:0] pack_exp();
    logic [PHV_LEN-1:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p[1123 - 48*i -: 48] = e6[i];
      p[739  - 32*i -: 32] = e4[i];
      p[483  - 16*i -: 16] = e2[i];
    end
    p[127:0] = emeta;
    return p;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 8; i++) begin
      e6[i] = '0; e4[i] = '0; e2[i] = '0;
    end
    emeta = '0;
  endtask

  // Expected containers for table c0@60, c8@26, c16@40 with header byte k = k + 7p
  task automatic set_exp_p(input int p, input logic [127:0] user);
    clear_exp();
    e6[0] = {bv(60, p), bv(61, p), bv(62, p), bv(63, p), 16'h0000};
    e4[0] = {bv(26, p), bv(27, p), bv(28, p), bv(29, p)};
    e2[0] = {bv(40, p), bv(41, p)};
    emeta = user;
  endtask

  task automatic cfg(input int addr, input logic [6:0] data);
    cfg_wr_en = 1'b1;
    cfg_addr  = 5'(addr);
    cfg_data  = data;
    @(negedge axis_clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;
    repeat (n) @(negedge axis_clk);
  endtask

  task automatic drive_beat(input int b, input int p, input bit last, input logic [127:0] user);
    for (int j = 0; j < 32; j++) s_axis.tdata[8*j +: 8] = bv(b * 32 + j, p);
    s_axis.tkeep  = last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    s_axis.tuser  = user;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = last;
  endtask

  // Sends one packet; the expected PHV is queued once the header-completing beat is accepted
  task automatic send_pkt(input int nbeats, input int p, input logic [127:0] user,
                          input bit toggle, input bit push);
    int acc;
    bit done;
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(b, p, b == nbeats - 1, user);
      done = 1'b0;
      acc  = 0;
      for (int t = 0; t < 4 && !done; t++) begin
        m_axis.tready = toggle ? ~m_axis.tready : 1'b1;
        if (m_axis.tready) begin
          acc  = cyc;
          done = 1'b1;
        end
        @(negedge axis_clk);
      end
      if (!done) check("beat_accept_timeout", 256'(0), 256'(1));
      if (push && (b == ((nbeats > 1) ? 1 : 0))) sb.push_back('{pack_exp(), acc + 2});
    end
  endtask

  // Monitor: pass-through equality every cycle, PHV scoreboard on each valid pulse
  always @(negedge axis_clk) begin
    exp_t e;
    check("s_tready", 256'(s_axis.tready), 256'(m_axis.tready));
    if (s_axis.tvalid) begin
      check("m_tdata", m_axis.tdata, s_axis.tdata);
      check("m_ctrl", 256'({m_axis.tkeep, m_axis.tuser, m_axis.tvalid, m_axis.tlast}),
                      256'({s_axis.tkeep, s_axis.tuser, s_axis.tvalid, s_axis.tlast}));
    end
    if (phv_out_valid) begin
      if (sb.size() == 0) begin
        check("phv_unexpected", 256'(1), 256'(0));
      end else begin
        e = sb.pop_front();
        check("phv_latency", 256'(cyc), 256'(e.exp_cyc));
        for (int c = 0; c < 5; c++)
          check($sformatf("phv_chunk%0d", c), 256'(phv_out >> (256 * c)), 256'(e.phv >> (256 * c)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn       = 1'b0;
    cfg_wr_en     = 1'b0;
    cfg_addr      = '0;
    cfg_data      = '0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tuser  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;
    clear_exp();
    repeat (3) @(negedge axis_clk);
    check("rst_phv_zero", 256'(phv_out != '0), 256'(0));
    check("rst_valid", 256'(phv_out_valid), 256'(0));
    aresetn = 1'b1;
    idle(2);

    // 2-beat packet, three valid entries
    cfg(0, {1'b1, 6'd0});
    cfg(8, {1'b1, 6'd26});
    cfg(16, {1'b1, 6'd12});
    clear_exp();
    e6[0] = 48'h0001_0203_0405;
    e4[0] = 32'h1A1B_1C1D;
    e2[0] = 16'h0C0D;
    emeta = 128'h1111;
    send_pkt(2, 0, 128'h1111, 1'b0, 1'b1);
    idle(4);

    // 1-beat packet: upper header half reads as zero
    cfg(16, {1'b1, 6'd40});
    e2[0] = 16'h0000;
    emeta = 128'hABCD;
    send_pkt(1, 0, 128'hABCD, 1'b0, 1'b1);
    idle(4);

    // offset 60 on a 6-byte container runs past the window
    cfg(0, {1'b1, 6'd60});
    e6[0] = 48'h3C3D_3E3F_0000;
    e2[0] = 16'h2829;
    emeta = 128'h3;
    send_pkt(2, 0, 128'h3, 1'b0, 1'b1);
    idle(4);

    // back-to-back 5-beat packets under 50% downstream ready, then 2-beat pairs
    for (int p = 1; p <= 3; p++) begin
      set_exp_p(p, 128'(256 + p));
      send_pkt(5, p, 128'(256 + p), 1'b1, 1'b1);
    end
    idle(2);
    for (int p = 4; p <= 5; p++) begin
      set_exp_p(p, 128'(256 + p));
      send_pkt(2, p, 128'(256 + p), 1'b0, 1'b1);
    end
    idle(6);

    // table write in the EMIT cycle only affects the following packet
    set_exp_p(0, 128'h55);
    send_pkt(2, 0, 128'h55, 1'b0, 1'b1);
    cfg_wr_en = 1'b1;
    cfg_addr  = 5'd8;
    cfg_data  = {1'b1, 6'd4};
    s_axis.tvalid = 1'b0;
    @(negedge axis_clk);
    cfg_wr_en = 1'b0;
    idle(4);
    set_exp_p(0, 128'h56);
    e4[0] = 32'h0405_0607;
    send_pkt(2, 0, 128'h56, 1'b0, 1'b1);
    idle(6);

    // reset while beat 1 is on the bus: no PHV, table cleared
    drive_beat(0, 0, 1'b0, 128'h77);
    @(negedge axis_clk);
    drive_beat(1, 0, 1'b0, 128'h77);
    aresetn = 1'b0;
    #1;
    check("midrst_phv_zero", 256'(phv_out != '0), 256'(0));
    check("midrst_valid", 256'(phv_out_valid), 256'(0));
    @(negedge axis_clk);
    s_axis.tvalid = 1'b0;
    @(negedge axis_clk);
    aresetn = 1'b1;
    idle(4);
    clear_exp();
    emeta = 128'h66;
    send_pkt(2, 0, 128'h66, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge axis_clk);
    check("sb_empty", 256'(sb.size()), 256'(0));
    idle(4);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
